// File: rtl/cdb_broadcaster.sv
`default_nettype none
// ============================================================================
// Module      : cdb_broadcaster
// Description : Common-data-bus producer. Accepts completed results from
//               NUM_FU functional units through valid/ready handshakes. Each
//               unit has a one-entry buffer. A rotating-priority arbiter picks
//               one buffered result per cycle and drives a registered
//               broadcast of ROB tag, value and source FU index.
//               Optional build macro CDB_BYPASS_EN: when every buffer is
//               empty, incoming results are arbitrated directly and the
//               winner reaches the CDB one edge earlier.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_broadcaster #(
    parameter int NUM_FU    = 4,
    parameter int ROB_IDX_W = 5,
    parameter int XLEN      = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        squash,
    input  logic [NUM_FU-1:0]           fu_valid,
    input  logic [NUM_FU*ROB_IDX_W-1:0] fu_tag,
    input  logic [NUM_FU*XLEN-1:0]      fu_value,
    output logic [NUM_FU-1:0]           fu_ready,
    output logic                        cdb_valid,
    output logic [ROB_IDX_W-1:0]        cdb_tag,
    output logic [XLEN-1:0]             cdb_value,
    output logic [$clog2(NUM_FU)-1:0]   cdb_fu_id
);

    localparam int c_PTR_W = $clog2(NUM_FU);

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Index following idx, wrapping from NUM_FU-1 back to 0.
    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] idx);
        logic [c_PTR_W-1:0] nxt;
        if (idx == c_PTR_W'(NUM_FU - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + c_PTR_W'(1);
        end
        return nxt;
    endfunction

    // First set request scanning upward from start with wrap; one-hot or 0.
    function automatic logic [NUM_FU-1:0] f_rr_pick(
        input logic [NUM_FU-1:0]  req,
        input logic [c_PTR_W-1:0] start
    );
        logic [NUM_FU-1:0]  gnt;
        logic               found;
        logic [c_PTR_W-1:0] idx;
        gnt   = '0;
        found = 1'b0;
        idx   = start;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
            idx = f_next(idx);
        end
        return gnt;
    endfunction

    // One-hot to binary index.
    function automatic logic [c_PTR_W-1:0] f_encode(input logic [NUM_FU-1:0] gnt);
        logic [c_PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (gnt[i]) begin
                idx = idx | c_PTR_W'(i);
            end
        end
        return idx;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_FU-1:0]    r_buf_valid;
    logic [ROB_IDX_W-1:0] r_buf_tag   [NUM_FU];
    logic [XLEN-1:0]      r_buf_value [NUM_FU];
    logic [c_PTR_W-1:0]   r_ptr;

    logic                 r_cdb_valid;
    logic [ROB_IDX_W-1:0] r_cdb_tag;
    logic [XLEN-1:0]      r_cdb_value;
    logic [c_PTR_W-1:0]   r_cdb_fu_id;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [ROB_IDX_W-1:0] w_fu_tag   [NUM_FU];
    logic [XLEN-1:0]      w_fu_value [NUM_FU];
    logic [NUM_FU-1:0]    w_buf_grant;
    logic [NUM_FU-1:0]    w_fu_ready;
    logic [NUM_FU-1:0]    w_xfer;
    logic [NUM_FU-1:0]    w_buf_write;
    logic [NUM_FU-1:0]    w_win_grant;
    logic                 w_win_any;
    logic [c_PTR_W-1:0]   w_win_idx;
    logic [ROB_IDX_W-1:0] w_win_tag;
    logic [XLEN-1:0]      w_win_value;

    // Split the flat per-FU input buses into indexable arrays.
    generate
        for (genvar i = 0; i < NUM_FU; i++) begin : g_unpack
            assign w_fu_tag[i]   = fu_tag[i*ROB_IDX_W +: ROB_IDX_W];
            assign w_fu_value[i] = fu_value[i*XLEN +: XLEN];
        end
    endgenerate

    // Buffer arbitration; a grant in a squash cycle is thrown away.
    always_comb begin
        w_buf_grant = '0;
        if (!squash) begin
            w_buf_grant = f_rr_pick(r_buf_valid, r_ptr);
        end
    end

    // A buffer accepts when empty or when it is being drained this edge.
    assign w_fu_ready = {NUM_FU{!squash}} & (~r_buf_valid | w_buf_grant);
    assign w_xfer     = fu_valid & w_fu_ready;

`ifdef CDB_BYPASS_EN
    logic [NUM_FU-1:0] w_byp_grant;
    logic              w_byp_sel;

    // With every buffer empty the live inputs compete directly; the winner
    // skips its buffer and the losers are parked in theirs.
    always_comb begin
        w_byp_grant = '0;
        if (!squash && (r_buf_valid == '0)) begin
            w_byp_grant = f_rr_pick(fu_valid, r_ptr);
        end
    end

    assign w_byp_sel   = |w_byp_grant;
    assign w_win_grant = w_buf_grant | w_byp_grant;
    assign w_buf_write = w_xfer & ~w_byp_grant;
    assign w_win_idx   = f_encode(w_win_grant);
    assign w_win_tag   = w_byp_sel ? w_fu_tag[w_win_idx]   : r_buf_tag[w_win_idx];
    assign w_win_value = w_byp_sel ? w_fu_value[w_win_idx] : r_buf_value[w_win_idx];
`else
    assign w_win_grant = w_buf_grant;
    assign w_buf_write = w_xfer;
    assign w_win_idx   = f_encode(w_win_grant);
    assign w_win_tag   = r_buf_tag[w_win_idx];
    assign w_win_value = r_buf_value[w_win_idx];
`endif

    assign w_win_any = |w_win_grant;

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------

    // Per-FU buffers: squash empties all; a refill wins over a drain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_buf_valid <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                r_buf_tag[i]   <= '0;
                r_buf_value[i] <= '0;
            end
        end else if (squash) begin
            r_buf_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_buf_write[i]) begin
                    r_buf_valid[i] <= 1'b1;
                    r_buf_tag[i]   <= w_fu_tag[i];
                    r_buf_value[i] <= w_fu_value[i];
                end else if (w_buf_grant[i]) begin
                    r_buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Priority pointer moves past the most recent winner; holds otherwise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (w_win_any) begin
            r_ptr <= f_next(w_win_idx);
        end
    end

    // Registered broadcast; payload holds when nothing is granted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_value <= '0;
            r_cdb_fu_id <= '0;
        end else if (w_win_any) begin
            r_cdb_valid <= 1'b1;
            r_cdb_tag   <= w_win_tag;
            r_cdb_value <= w_win_value;
            r_cdb_fu_id <= w_win_idx;
        end else begin
            r_cdb_valid <= 1'b0;
        end
    end

    assign fu_ready  = w_fu_ready;
    assign cdb_valid = r_cdb_valid;
    assign cdb_tag   = r_cdb_tag;
    assign cdb_value = r_cdb_value;
    assign cdb_fu_id = r_cdb_fu_id;

endmodule

`default_nettype wire

// File: tb/tb_cdb_broadcaster.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_broadcaster
// Description : Directed self-checking bench for cdb_broadcaster
//               (NUM_FU=4, ROB_IDX_W=5, XLEN=32). Honours CDB_BYPASS_EN for
//               the latency-dependent expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_broadcaster;

    logic         clock;
    logic         reset;
    logic         squash;
    logic [3:0]   fu_valid;
    logic [19:0]  fu_tag;
    logic [127:0] fu_value;
    logic [3:0]   fu_ready;
    logic         cdb_valid;
    logic [4:0]   cdb_tag;
    logic [31:0]  cdb_value;
    logic [1:0]   cdb_fu_id;

    logic [4:0]   tb_tag [4];
    logic [31:0]  tb_val [4];

    int errors = 0;
    int checks = 0;

    assign fu_tag   = {tb_tag[3], tb_tag[2], tb_tag[1], tb_tag[0]};
    assign fu_value = {tb_val[3], tb_val[2], tb_val[1], tb_val[0]};

    cdb_broadcaster #(
        .NUM_FU    (4),
        .ROB_IDX_W (5),
        .XLEN      (32)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .squash    (squash),
        .fu_valid  (fu_valid),
        .fu_tag    (fu_tag),
        .fu_value  (fu_value),
        .fu_ready  (fu_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value),
        .cdb_fu_id (cdb_fu_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic [1:0] idx, input logic [4:0] t, input logic [31:0] v);
        fu_valid[idx] = 1'b1;
        tb_tag[idx]   = t;
        tb_val[idx]   = v;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        squash   = 1'b0;
        fu_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tb_tag[i] = 5'(i + 9);
            tb_val[i] = 32'h5555_0000 + 32'(i);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (cdb_valid !== 1'b0 || cdb_tag !== 5'd0 || cdb_value !== 32'd0 || cdb_fu_id !== 2'd0) begin
                errors++;
                $display("FAIL reset_outputs: got v=%0b t=%0d val=%h id=%0d want all 0", cdb_valid, cdb_tag, cdb_value, cdb_fu_id);
            end
            checks++;
            if (fu_ready !== 4'b1111) begin
                errors++;
                $display("FAIL reset_ready: got %b want 1111", fu_ready);
            end
        end
        fu_valid = 4'b0000;
        reset    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (cdb_valid !== 1'b0 || cdb_tag !== 5'd0 || cdb_value !== 32'd0) begin
                errors++;
                $display("FAIL idle_after_reset: got v=%0b t=%0d val=%h want 0/0/0", cdb_valid, cdb_tag, cdb_value);
            end
        end
        checks++;
        if (fu_ready !== 4'b1111) begin
            errors++;
            $display("FAIL idle_ready: got %b want 1111", fu_ready);
        end
    endtask

    // Four simultaneous results from pointer 0; a second wave stalls behind
    // them so each FU only sees ready in its own grant cycle.
    task automatic test_rotation();
        logic [3:0] exp_ready;
        for (int i = 0; i < 4; i++) present(2'(i), 5'(i + 1), 32'hA000_0000 + 32'(i + 1));
        #1;
        checks++;
        if (fu_ready !== 4'b1111) begin
            errors++;
            $display("FAIL rot_ready_empty: got %b want 1111", fu_ready);
        end
        tick();
        for (int i = 0; i < 4; i++) present(2'(i), 5'(i + 5), 32'hA000_0000 + 32'(i + 5));
        for (int g = 0; g < 4; g++) begin
            #1;
            exp_ready = 4'b0001 << g;
            checks++;
            if (fu_ready !== exp_ready) begin
                errors++;
                $display("FAIL rot_ready_grant%0d: got %b want %b", g, fu_ready, exp_ready);
            end
            tick();
            fu_valid[g] = 1'b0;
            checks++;
            if (cdb_valid !== 1'b1 || cdb_fu_id !== 2'(g) || cdb_tag !== 5'(g + 1) || cdb_value !== 32'hA000_0000 + 32'(g + 1)) begin
                errors++;
                $display("FAIL rot_bcast%0d: got v=%0b id=%0d t=%0d val=%h want v=1 id=%0d t=%0d", g, cdb_valid, cdb_fu_id, cdb_tag, cdb_value, g, g + 1);
            end
        end
        for (int g = 0; g < 4; g++) begin
            tick();
            checks++;
            if (cdb_valid !== 1'b1 || cdb_fu_id !== 2'(g) || cdb_tag !== 5'(g + 5) || cdb_value !== 32'hA000_0000 + 32'(g + 5)) begin
                errors++;
                $display("FAIL rot_wave2_%0d: got v=%0b id=%0d t=%0d want v=1 id=%0d t=%0d", g, cdb_valid, cdb_fu_id, cdb_tag, g, g + 5);
            end
        end
        tick();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL rot_drained: got v=%0b want 0", cdb_valid);
        end
    endtask

    task automatic test_single();
        present(2'd2, 5'd7, 32'hDEAD_BEEF);
        tick();
        fu_valid = 4'b0000;
`ifndef CDB_BYPASS_EN
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: got v=%0b want 0 one edge after accept", cdb_valid);
        end
        tick();
`endif
        checks++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 5'd7 || cdb_value !== 32'hDEAD_BEEF || cdb_fu_id !== 2'd2) begin
            errors++;
            $display("FAIL single_bcast: got v=%0b t=%0d val=%h id=%0d want 1/7/deadbeef/2", cdb_valid, cdb_tag, cdb_value, cdb_fu_id);
        end
        tick();
        checks++;
        if (cdb_valid !== 1'b0 || cdb_tag !== 5'd7 || cdb_fu_id !== 2'd2) begin
            errors++;
            $display("FAIL single_one_cycle: got v=%0b t=%0d id=%0d want 0 with tag 7 id 2 held", cdb_valid, cdb_tag, cdb_fu_id);
        end
    endtask

    // Pointer sits at 3: FU3 goes before FU0, leaving the pointer at 1,
    // which the second burst (FU1 before FU3 before FU0) confirms.
    task automatic test_pointer_wrap();
        present(2'd0, 5'd10, 32'h0000_0010);
        present(2'd3, 5'd13, 32'h0000_0013);
        tick();
        fu_valid = 4'b0000;
`ifndef CDB_BYPASS_EN
        #1;
        checks++;
        if (fu_ready !== 4'b1110) begin
            errors++;
            $display("FAIL wrap_ready: got %b want 1110", fu_ready);
        end
        tick();
`endif
        checks++;
        if (cdb_valid !== 1'b1 || cdb_fu_id !== 2'd3 || cdb_tag !== 5'd13) begin
            errors++;
            $display("FAIL wrap_first: got v=%0b id=%0d t=%0d want 1/3/13", cdb_valid, cdb_fu_id, cdb_tag);
        end
        tick();
        checks++;
        if (cdb_valid !== 1'b1 || cdb_fu_id !== 2'd0 || cdb_tag !== 5'd10 || cdb_value !== 32'h0000_0010) begin
            errors++;
            $display("FAIL wrap_second: got v=%0b id=%0d t=%0d want 1/0/10", cdb_valid, cdb_fu_id, cdb_tag);
        end
        tick();
        present(2'd0, 5'd20, 32'h0000_0020);
        present(2'd1, 5'd21, 32'h0000_0021);
        present(2'd3, 5'd23, 32'h0000_0023);
        tick();
        fu_valid = 4'b0000;
`ifndef CDB_BYPASS_EN
        tick();
`endif
        checks++;
        if (cdb_valid !== 1'b1 || cdb_fu_id !== 2'd1 || cdb_tag !== 5'd21) begin
            errors++;
            $display("FAIL ptr_is_1: got v=%0b id=%0d t=%0d want 1/1/21", cdb_valid, cdb_fu_id, cdb_tag);
        end
        tick();
        checks++;
        if (cdb_valid !== 1'b1 || cdb_fu_id !== 2'd3 || cdb_tag !== 5'd23) begin
            errors++;
            $display("FAIL ptr_then_3: got v=%0b id=%0d t=%0d want 1/3/23", cdb_valid, cdb_fu_id, cdb_tag);
        end
        tick();
        checks++;
        if (cdb_valid !== 1'b1 || cdb_fu_id !== 2'd0 || cdb_tag !== 5'd20) begin
            errors++;
            $display("FAIL ptr_then_0: got v=%0b id=%0d t=%0d want 1/0/20", cdb_valid, cdb_fu_id, cdb_tag);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 8; j++) begin
            present(2'd1, 5'(16 + j), 32'hB000_0000 + 32'(j));
            #1;
            checks++;
            if (fu_ready[1] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready%0d: got %b want bit1 set", j, fu_ready);
            end
            tick();
`ifdef CDB_BYPASS_EN
            checks++;
            if (cdb_valid !== 1'b1 || cdb_tag !== 5'(16 + j) || cdb_fu_id !== 2'd1 || cdb_value !== 32'hB000_0000 + 32'(j)) begin
                errors++;
                $display("FAIL b2b_bcast%0d: got v=%0b t=%0d id=%0d want 1/%0d/1", j, cdb_valid, cdb_tag, cdb_fu_id, 16 + j);
            end
`else
            checks++;
            if (j == 0) begin
                if (cdb_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_first_latency: got v=%0b want 0", cdb_valid);
                end
            end else if (cdb_valid !== 1'b1 || cdb_tag !== 5'(15 + j) || cdb_fu_id !== 2'd1 || cdb_value !== 32'hB000_0000 + 32'(j - 1)) begin
                errors++;
                $display("FAIL b2b_bcast%0d: got v=%0b t=%0d id=%0d want 1/%0d/1", j, cdb_valid, cdb_tag, cdb_fu_id, 15 + j);
            end
`endif
        end
        fu_valid = 4'b0000;
`ifndef CDB_BYPASS_EN
        tick();
        checks++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 5'd23) begin
            errors++;
            $display("FAIL b2b_last: got v=%0b t=%0d want 1/23", cdb_valid, cdb_tag);
        end
`endif
        tick();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got v=%0b want 0", cdb_valid);
        end
    endtask

    task automatic test_squash();
        logic [4:0] exp_hold;
`ifdef CDB_BYPASS_EN
        exp_hold = 5'd26;
`else
        exp_hold = 5'd23;
`endif
        present(2'd0, 5'd30, 32'hC000_0030);
        present(2'd2, 5'd26, 32'hC000_0026);
        present(2'd3, 5'd27, 32'hC000_0027);
        tick();
        fu_valid = 4'b0000;
        squash   = 1'b1;
        #1;
        checks++;
        if (fu_ready !== 4'b0000) begin
            errors++;
            $display("FAIL squash_ready: got %b want 0000", fu_ready);
        end
        tick();
        squash = 1'b0;
        checks++;
        if (cdb_valid !== 1'b0 || cdb_tag !== exp_hold) begin
            errors++;
            $display("FAIL squash_cdb: got v=%0b t=%0d want 0 with tag %0d held", cdb_valid, cdb_tag, exp_hold);
        end
        #1;
        checks++;
        if (fu_ready !== 4'b1111) begin
            errors++;
            $display("FAIL squash_empty: got ready %b want 1111", fu_ready);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (cdb_valid !== 1'b0) begin
                errors++;
                $display("FAIL squash_stale%0d: got v=%0b t=%0d want no broadcast", c, cdb_valid, cdb_tag);
            end
        end
    endtask

    task automatic test_reset_midop();
        present(2'd0, 5'd3, 32'hD000_0003);
        present(2'd1, 5'd4, 32'hD000_0004);
        tick();
        fu_valid = 4'b0000;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (cdb_valid !== 1'b0 || cdb_tag !== 5'd0 || cdb_value !== 32'd0 || cdb_fu_id !== 2'd0 || fu_ready !== 4'b1111) begin
            errors++;
            $display("FAIL midop_reset: got v=%0b t=%0d val=%h id=%0d rdy=%b want 0/0/0/0/1111", cdb_valid, cdb_tag, cdb_value, cdb_fu_id, fu_ready);
        end
        #1;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (cdb_valid !== 1'b0) begin
                errors++;
                $display("FAIL midop_dropped%0d: got v=%0b t=%0d want 0", c, cdb_valid, cdb_tag);
            end
        end
        present(2'd0, 5'd1, 32'hE000_0001);
        present(2'd3, 5'd2, 32'hE000_0002);
        tick();
        fu_valid = 4'b0000;
`ifndef CDB_BYPASS_EN
        tick();
`endif
        checks++;
        if (cdb_valid !== 1'b1 || cdb_fu_id !== 2'd0 || cdb_tag !== 5'd1) begin
            errors++;
            $display("FAIL midop_ptr0: got v=%0b id=%0d t=%0d want 1/0/1", cdb_valid, cdb_fu_id, cdb_tag);
        end
        tick();
        checks++;
        if (cdb_valid !== 1'b1 || cdb_fu_id !== 2'd3 || cdb_tag !== 5'd2) begin
            errors++;
            $display("FAIL midop_next3: got v=%0b id=%0d t=%0d want 1/3/2", cdb_valid, cdb_fu_id, cdb_tag);
        end
    endtask

    initial begin
        test_reset();
`ifndef CDB_BYPASS_EN
        test_rotation();
`endif
        test_single();
        test_pointer_wrap();
        test_back_to_back();
        test_squash();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/cdb_broadcaster.md
Name: cdb_broadcaster

Overview:
- Producer side of the common data bus (CDB) consumed by the reservation station, map table and ROB.
- Collects completed results from NUM_FU functional units through valid/ready handshakes and holds each in a one-entry per-FU buffer.
- Selects one buffered result per cycle with a rotating-priority arbiter and drives it as a registered broadcast of ROB tag plus value.
- Sits between the execute stage and every CDB consumer.

Parameters:
- NUM_FU, 4, number of functional-unit completion ports (at least 2).
- ROB_IDX_W, 5, ROB tag width, equal to $clog2(`ROB_SIZE).
- XLEN, 32, result value width.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous active-low reset; state clears immediately when 0.
- squash  input  1  branch-mispredict flush; synchronous.
- fu_valid  input  NUM_FU  per-FU result valid.
- fu_tag  input  NUM_FU*ROB_IDX_W  per-FU destination ROB tag; FU i occupies bits [i*ROB_IDX_W +: ROB_IDX_W].
- fu_value  input  NUM_FU*XLEN  per-FU result value; FU i occupies bits [i*XLEN +: XLEN].
- fu_ready  output  NUM_FU  per-FU buffer can accept.
- cdb_valid  output  1  broadcast valid this cycle.
- cdb_tag  output  ROB_IDX_W  broadcast ROB tag.
- cdb_value  output  XLEN  broadcast value.
- cdb_fu_id  output  $clog2(NUM_FU)  index of the FU whose result is broadcast.

Behaviour:
- Reset (reset == 0):
  - All buffers invalid; priority pointer is 0.
  - cdb_valid, cdb_tag, cdb_value and cdb_fu_id are all 0.
  - fu_ready is all 1 while not squashing.
- Buffers: buf_valid[i], buf_tag[i], buf_value[i]. A transfer on FU i happens at an edge where fu_valid[i] && fu_ready[i]; that edge writes buf[i].
- Readiness: fu_ready[i] = !squash && (!buf_valid[i] || grant[i]). This is a combinational path from grant, so a buffer can be drained and refilled at the same edge.
- Arbitration (combinational over buf_valid):
  - Scan starts at index ptr and wraps modulo NUM_FU; the first valid buffer wins.
  - grant is one-hot or all 0.
- Broadcast (registered):
  - At each edge, cdb_valid <= |grant, and cdb_tag, cdb_value and cdb_fu_id take the winner's contents.
  - When there is no grant, cdb_valid <= 0 and the other CDB outputs hold their values.
  - The granted buffer clears at the same edge unless it is refilled by a new transfer.
- Latency: a result accepted at edge k is broadcast after edge k+1 if it wins, i.e. it is visible for one cycle following that edge. The CDB is never back-pressured.
- Pointer update: after a grant to index i, ptr <= (i+1) mod NUM_FU. The pointer holds when there is no grant. The wrap from NUM_FU-1 goes to 0.
- Fairness bound: a valid buffer waits at most NUM_FU-1 cycles before it is granted.
- Full condition: all buffers valid means exactly one FU sees fu_ready = 1 (the granted one). The others stall, holding their valid and data stable until accepted.
- Squash:
  - At the edge where squash == 1, all buffers clear and cdb_valid <= 0. The pointer is not reset.
  - fu_ready is 0 during the squash cycle, so no transfer occurs.
  - A grant computed in the squash cycle is discarded.
- Reset mid-operation: buffered and in-flight results are dropped. No broadcast may appear after reset is released until a new transfer occurs.
- Tags are passed through unmodified; no tag-0 special case.

Optional Feature:
- Macro: CDB_BYPASS_EN.
- With the macro defined:
  - When all buffers are empty, incoming fu_valid lines are arbitrated directly with the same pointer.
  - The winner is registered straight to the CDB outputs at the accepting edge, giving a latency of 1 (visible after edge k).
  - Non-winning valid inputs are written into their buffers at that same edge.
  - Squash suppresses the bypass path.
- Without the macro: every result passes through its buffer, and the minimum latency is 2 edges.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles with fu_valid=4'b1111, then release with fu_valid=0 -> cdb_valid stays 0, cdb_tag and cdb_value are 0, fu_ready=4'b1111.
- Single result: FU2 presents tag=5'd7, value=32'hDEADBEEF for one cycle -> after the next edge cdb_valid=1, cdb_tag=7, cdb_value=DEADBEEF, cdb_fu_id=2 for exactly one cycle; this is one edge earlier with CDB_BYPASS_EN.
- Rotation and fairness: all 4 FUs present tags 1,2,3,4 simultaneously and hold valid -> broadcasts occur in cdb_fu_id order 0,1,2,3 on consecutive cycles; each fu_ready rises only in its grant cycle.
- Pointer wrap: ptr=3 after granting FU2, then FU0 and FU3 become valid together -> FU3 broadcasts first, then FU0; ptr returns to 1.
- Back-to-back on one FU: FU1 keeps fu_valid=1 with a new tag every cycle, others idle -> a broadcast every cycle with tags in sequence, no bubbles, fu_ready[1] held 1.
- Squash: three buffers valid, assert squash for one cycle -> next cycle cdb_valid=0, all buffers empty, no old tag is ever broadcast afterwards; fu_ready=0 during the squash cycle.
